// File: rtl/bus_decoder.sv
// Address decoder between the PicoRV32 native bus, the program ROM and the SPI/QSPI register block.
// Optional WAIT-state timeout abort is compiled in with `define BUS_TIMEOUT_EN.
module bus_decoder #(
    parameter logic [31:0] MEM_BASE       = 32'h0010_0000,
    parameter logic [31:0] MEM_MASK       = 32'hFFF0_0000,
    parameter logic [31:0] PER_BASE       = 32'h2000_0000,
    parameter logic [31:0] PER_MASK       = 32'hF000_0000,
    parameter int          TIMEOUT_CYCLES = 16,
    parameter int          CNT_W          = 5,
    parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        cpu_valid,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_wstrb,
    output logic        cpu_ready,
    output logic [31:0] cpu_rdata,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        per_valid,
    output logic [31:0] per_addr,
    output logic [31:0] per_wdata,
    output logic [3:0]  per_wstrb,
    input  logic        per_ready,
    input  logic [31:0] per_rdata,
    output logic        bus_err
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      r_state,     w_state_next;
    logic        r_sel_per,   w_sel_per_next;
    logic        r_cpu_ready, w_cpu_ready_next;
    logic [31:0] r_cpu_rdata, w_cpu_rdata_next;
    logic        r_bus_err,   w_bus_err_next;
    logic        r_mem_valid, w_mem_valid_next;
    logic [31:0] r_mem_addr,  w_mem_addr_next;
    logic        r_per_valid, w_per_valid_next;
    logic [31:0] r_per_addr,  w_per_addr_next;
    logic [31:0] r_per_wdata, w_per_wdata_next;
    logic [3:0]  r_per_wstrb, w_per_wstrb_next;

    logic        w_mem_hit;
    logic        w_per_hit;
    logic        w_is_write;
    logic        w_slave_ready;
    logic [31:0] w_slave_rdata;

    assign w_mem_hit  = (cpu_addr & MEM_MASK) == MEM_BASE;
    assign w_per_hit  = (cpu_addr & PER_MASK) == PER_BASE;
    assign w_is_write = |cpu_wstrb;

    // Only the slave that owns the transaction is listened to; the other one's ready is don't-care.
    assign w_slave_ready = r_sel_per ? per_ready : mem_ready;
    assign w_slave_rdata = r_sel_per ? per_rdata : mem_rdata;

    // An empty block whose condition keeps the counter sizing parameters tied into elaboration.
    if (TIMEOUT_CYCLES > (1 << CNT_W)) begin : g_cnt_w_too_narrow
    end

`ifdef BUS_TIMEOUT_EN
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
`endif

    always_comb begin
        w_state_next     = r_state;
        w_sel_per_next   = r_sel_per;
        w_cpu_ready_next = 1'b0;
        w_cpu_rdata_next = r_cpu_rdata;
        w_bus_err_next   = 1'b0;
        w_mem_valid_next = r_mem_valid;
        w_mem_addr_next  = r_mem_addr;
        w_per_valid_next = r_per_valid;
        w_per_addr_next  = r_per_addr;
        w_per_wdata_next = r_per_wdata;
        w_per_wstrb_next = r_per_wstrb;
`ifdef BUS_TIMEOUT_EN
        w_cnt_next       = r_cnt;
`endif
        unique case (r_state)
            IDLE: begin
                if (cpu_valid) begin
                    w_mem_addr_next  = cpu_addr;
                    w_per_addr_next  = cpu_addr;
                    w_per_wdata_next = cpu_wdata;
                    w_per_wstrb_next = cpu_wstrb;
`ifdef BUS_TIMEOUT_EN
                    w_cnt_next       = '0;
`endif
                    if (w_mem_hit && !w_is_write) begin
                        w_mem_valid_next = 1'b1;
                        w_sel_per_next   = 1'b0;
                        w_state_next     = WAIT;
                    end else if (!w_mem_hit && w_per_hit) begin
                        w_per_valid_next = 1'b1;
                        w_sel_per_next   = 1'b1;
                        w_state_next     = WAIT;
                    end else begin
                        // ROM write or unmapped address: answer immediately with an error.
                        w_cpu_rdata_next = ERR_DATA;
                        w_bus_err_next   = 1'b1;
                        w_cpu_ready_next = 1'b1;
                        w_state_next     = RESP;
                    end
                end
            end
            WAIT: begin
                if (w_slave_ready) begin
                    w_cpu_rdata_next = w_slave_rdata;
                    w_mem_valid_next = 1'b0;
                    w_per_valid_next = 1'b0;
                    w_cpu_ready_next = 1'b1;
                    w_state_next     = RESP;
`ifdef BUS_TIMEOUT_EN
                end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    w_cpu_rdata_next = ERR_DATA;
                    w_bus_err_next   = 1'b1;
                    w_mem_valid_next = 1'b0;
                    w_per_valid_next = 1'b0;
                    w_cpu_ready_next = 1'b1;
                    w_state_next     = RESP;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
`endif
                end
            end
            RESP: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= IDLE;
            r_sel_per   <= 1'b0;
            r_cpu_ready <= 1'b0;
            r_cpu_rdata <= '0;
            r_bus_err   <= 1'b0;
            r_mem_valid <= 1'b0;
            r_mem_addr  <= '0;
            r_per_valid <= 1'b0;
            r_per_addr  <= '0;
            r_per_wdata <= '0;
            r_per_wstrb <= '0;
`ifdef BUS_TIMEOUT_EN
            r_cnt       <= '0;
`endif
        end else begin
            r_state     <= w_state_next;
            r_sel_per   <= w_sel_per_next;
            r_cpu_ready <= w_cpu_ready_next;
            r_cpu_rdata <= w_cpu_rdata_next;
            r_bus_err   <= w_bus_err_next;
            r_mem_valid <= w_mem_valid_next;
            r_mem_addr  <= w_mem_addr_next;
            r_per_valid <= w_per_valid_next;
            r_per_addr  <= w_per_addr_next;
            r_per_wdata <= w_per_wdata_next;
            r_per_wstrb <= w_per_wstrb_next;
`ifdef BUS_TIMEOUT_EN
            r_cnt       <= w_cnt_next;
`endif
        end
    end

    assign cpu_ready = r_cpu_ready;
    assign cpu_rdata = r_cpu_rdata;
    assign bus_err   = r_bus_err;
    assign mem_valid = r_mem_valid;
    assign mem_addr  = r_mem_addr;
    assign per_valid = r_per_valid;
    assign per_addr  = r_per_addr;
    assign per_wdata = r_per_wdata;
    assign per_wstrb = r_per_wstrb;

endmodule

// File: tb/tb_bus_decoder.sv
// Directed bench for bus_decoder: ROM/peripheral slave models, a response scoreboard and latency checks.
`timescale 1ns/1ps
module tb_bus_decoder;

    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        cpu_valid = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic [3:0]  cpu_wstrb = '0;
    logic        cpu_ready;
    logic [31:0] cpu_rdata;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        per_valid;
    logic [31:0] per_addr;
    logic [31:0] per_wdata;
    logic [3:0]  per_wstrb;
    logic        per_ready;
    logic [31:0] per_rdata;
    logic        bus_err;

    bus_decoder dut (
        .clk(clk), .rstn(rstn),
        .cpu_valid(cpu_valid), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb),
        .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .per_valid(per_valid), .per_addr(per_addr), .per_wdata(per_wdata), .per_wstrb(per_wstrb),
        .per_ready(per_ready), .per_rdata(per_rdata),
        .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return (a == 32'h0010_0008) ? 32'h00F7_2423 : (a ^ 32'h5A5A_0000);
    endfunction

    function automatic logic [31:0] per_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    // Program ROM: registered ready that follows valid, so it lingers one cycle after valid drops.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem_ready <= 1'b0;
            mem_rdata <= '0;
        end else begin
            mem_ready <= mem_valid;
            mem_rdata <= mem_valid ? rom_word(mem_addr) : 32'h0;
        end
    end

    // Peripheral: ready pulses per_lat edges after valid is first seen, unless held off.
    int per_lat  = 1;
    bit per_hold = 1'b0;
    int per_cnt  = 0;
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            per_ready <= 1'b0;
            per_rdata <= '0;
            per_cnt   <= 0;
        end else if (per_valid && !per_ready && !per_hold) begin
            if (per_cnt == per_lat - 1) begin
                per_ready <= 1'b1;
                per_rdata <= per_word(per_addr);
                per_cnt   <= 0;
            end else begin
                per_cnt <= per_cnt + 1;
            end
        end else begin
            per_ready <= 1'b0;
        end
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        string       tag;
    } exp_t;
    exp_t exp_q[$];

    int          mem_rise   = 0;
    int          per_cycles = 0;
    logic        mv_prev    = 1'b0;
    logic [31:0] seen_mem_addr = '0;
    logic [31:0] seen_per_wdata = '0;
    logic [3:0]  seen_per_wstrb = '0;
    logic        resp_mem_valid = 1'b0;
    logic        resp_per_valid = 1'b0;

    // Response monitor: pops the scoreboard on every cpu_ready pulse.
    always @(posedge clk) begin
        #1;
        if (mem_valid && !mv_prev) mem_rise++;
        mv_prev = mem_valid;
        if (mem_valid) seen_mem_addr = mem_addr;
        if (per_valid) begin
            per_cycles++;
            seen_per_wdata = per_wdata;
            seen_per_wstrb = per_wstrb;
        end
        if (bus_err && !cpu_ready) check("bus_err_without_ready", 32'(bus_err), 32'(cpu_ready));
        if (cpu_ready) begin
            exp_t e;
            check("response_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check({e.tag, "_rdata"}, cpu_rdata, e.rdata);
                check({e.tag, "_bus_err"}, 32'(bus_err), 32'(e.err));
                $display("resp %s rdata=%h bus_err=%0b", e.tag, cpu_rdata, bus_err);
            end
            resp_mem_valid = mem_valid;
            resp_per_valid = per_valid;
        end
    end

    task automatic clear_stats();
        mem_rise   = 0;
        per_cycles = 0;
    endtask

    // One CPU request; expected response queued, latency counted in edges from the sampling edge.
    task automatic do_req(input string tag, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] ws, input logic [31:0] exp_rd, input logic exp_err,
                          input int exp_lat, input int budget);
        int  n;
        bit  seen;
        @(posedge clk); #1;
        exp_q.push_back('{rdata: exp_rd, err: exp_err, tag: tag});
        cpu_valid = 1'b1;
        cpu_addr  = a;
        cpu_wdata = wd;
        cpu_wstrb = ws;
        n = 0;
        seen = 1'b0;
        while (!seen && n < budget) begin
            @(posedge clk); #1;
            n++;
            if (cpu_ready) seen = 1'b1;
        end
        cpu_valid = 1'b0;
        check({tag, "_ready_seen"}, 32'(seen), 32'd1);
        if (seen) check({tag, "_latency"}, 32'(n), 32'(exp_lat));
        $display("req %s addr=%h wstrb=%h latency=%0d", tag, a, ws, n);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        bit seen;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_cpu_ready", 32'(cpu_ready), 32'd0);
        check("rst_cpu_rdata", cpu_rdata, 32'd0);
        check("rst_bus_err",   32'(bus_err), 32'd0);
        check("rst_mem_valid", 32'(mem_valid), 32'd0);
        check("rst_mem_addr",  mem_addr, 32'd0);
        check("rst_per_valid", 32'(per_valid), 32'd0);
        check("rst_per_addr",  per_addr, 32'd0);
        check("rst_per_wdata", per_wdata, 32'd0);
        check("rst_per_wstrb", 32'(per_wstrb), 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // ROM read
        clear_stats();
        do_req("rom_rd", 32'h0010_0008, 32'h0, 4'h0, 32'h00F7_2423, 1'b0, 3, 20);
        check("rom_rd_mem_addr", seen_mem_addr, 32'h0010_0008);
        check("rom_rd_mem_requests", 32'(mem_rise), 32'd1);
        check("rom_rd_valid_dropped", 32'(resp_mem_valid), 32'd0);
        check("rom_rd_no_per", 32'(per_cycles), 32'd0);

        // Peripheral write, ready four edges after valid
        clear_stats();
        per_lat = 4;
        do_req("per_wr", 32'h2001_0008, 32'h0202_019F, 4'hF, per_word(32'h2001_0008), 1'b0, 6, 30);
        check("per_wr_wdata", seen_per_wdata, 32'h0202_019F);
        check("per_wr_wstrb", 32'(seen_per_wstrb), 32'hF);
        check("per_wr_valid_cycles", 32'(per_cycles), 32'd5);
        check("per_wr_no_mem", 32'(mem_rise), 32'd0);
        check("per_wr_valid_dropped", 32'(resp_per_valid), 32'd0);

        // Peripheral read, single-cycle slave
        clear_stats();
        per_lat = 1;
        do_req("per_rd", 32'h2000_0010, 32'h0, 4'h0, per_word(32'h2000_0010), 1'b0, 3, 20);

        // Unmapped read and ROM write
        clear_stats();
        do_req("unmapped_rd", 32'h4000_0000, 32'h0, 4'h0, ERR, 1'b1, 1, 10);
        check("unmapped_no_mem", 32'(mem_rise), 32'd0);
        check("unmapped_no_per", 32'(per_cycles), 32'd0);
        clear_stats();
        do_req("rom_wr", 32'h0010_0000, 32'h1234_5678, 4'h3, ERR, 1'b1, 1, 10);
        check("rom_wr_no_mem", 32'(mem_rise), 32'd0);
        check("rom_wr_no_per", 32'(per_cycles), 32'd0);

        // Stalled peripheral
        clear_stats();
        per_hold = 1'b1;
`ifdef BUS_TIMEOUT_EN
        do_req("per_timeout", 32'h2000_0020, 32'h0, 4'h0, ERR, 1'b1, 17, 40);
        check("per_timeout_valid_cycles", 32'(per_cycles), 32'd16);
        per_hold = 1'b0;
`else
        @(posedge clk); #1;
        exp_q.push_back('{rdata: per_word(32'h2000_0020), err: 1'b0, tag: "per_stall"});
        cpu_valid = 1'b1;
        cpu_addr  = 32'h2000_0020;
        cpu_wstrb = 4'h0;
        cnt = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (cpu_ready) cnt++;
        end
        check("per_stall_no_ready", 32'(cnt), 32'd0);
        check("per_stall_valid_held", 32'(per_valid), 32'd1);
        per_hold = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            if (!seen) begin
                @(posedge clk); #1;
                if (cpu_ready) seen = 1'b1;
            end
        end
        cpu_valid = 1'b0;
        check("per_stall_released", 32'(seen), 32'd1);
`endif

        // Back-to-back ROM reads across the lingering mem_ready
        clear_stats();
        do_req("b2b_first",  32'h0010_0100, 32'h0, 4'h0, rom_word(32'h0010_0100), 1'b0, 3, 20);
        do_req("b2b_second", 32'h0010_0204, 32'h0, 4'h0, rom_word(32'h0010_0204), 1'b0, 3, 20);
        check("b2b_mem_requests", 32'(mem_rise), 32'd2);

        // Asynchronous reset while waiting on a stalled peripheral
        per_hold = 1'b1;
        @(posedge clk); #1;
        cpu_valid = 1'b1;
        cpu_addr  = 32'h2000_0030;
        cpu_wdata = 32'hCAFE_F00D;
        cpu_wstrb = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        check("midrst_in_wait", 32'(per_valid), 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        check("midrst_per_valid", 32'(per_valid), 32'd0);
        check("midrst_per_addr",  per_addr, 32'd0);
        check("midrst_per_wdata", per_wdata, 32'd0);
        check("midrst_per_wstrb", 32'(per_wstrb), 32'd0);
        check("midrst_others", {cpu_rdata[30:0], cpu_ready}, 32'd0);
        check("midrst_flags", {29'd0, bus_err, mem_valid, cpu_rdata[31]}, 32'd0);
        cpu_valid = 1'b0;
        per_hold  = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        clear_stats();
        do_req("post_rst_rd", 32'h0010_0008, 32'h0, 4'h0, 32'h00F7_2423, 1'b0, 3, 20);
        repeat (3) @(posedge clk);
        #2;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
